// File: rtl/cache_fill_arbiter.sv
// Round-robin block-fill engine: grants one cache miss at a time onto a pipelined memory read port.
// Optional macro CRITICAL_WORD_FIRST_EN: burst starts at the missing word and crit_word_ready pulses.
module cache_fill_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK),
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss_req,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_data_valid,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [NUM_CH-1:0]        fill_we,
    output logic [IDX_W-1:0]         fill_word_idx,
    output logic [DATA_W-1:0]        fill_data,
    output logic [NUM_CH-1:0]        tag_we,
    output logic [NUM_CH-1:0]        fill_done,
    output logic                     busy,
    output logic [NUM_CH-1:0]        crit_word_ready
);

    // The return side never needs MEM_LATENCY: it simply counts valid words.
    if (NUM_CH < 1 || NUM_CH > 4 || WORDS_PER_BLOCK < 2 || WORDS_PER_BLOCK > 16 ||
        (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
        MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_param_check
        $error("cache_fill_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [CH_W-1:0]           ptr_r;
    logic [CH_W-1:0]           gnt_ch_r;
    logic [ADDR_W-IDX_W-2:0]   base_hi_r;
    logic [IDX_W-1:0]          start_r;
    logic [IDX_W:0]            issue_cnt_r;
    logic [IDX_W-1:0]          ret_cnt_r;

    logic                      req_any_s;
    logic [CH_W-1:0]           gnt_s;
    logic [CH_W-1:0]           cand_s;
    logic [ADDR_W-1:0]         sel_addr_s;
    logic [IDX_W-1:0]          start_s;
    logic [IDX_W-1:0]          issue_word_s;
    logic [IDX_W-1:0]          ret_word_s;
    logic [NUM_CH-1:0]         grant_oh_s;
    logic                      unused_addr_bits_s;

    // Round-robin pick: offsets are walked far-to-near so the nearest requester at/after ptr wins.
    always_comb begin
        req_any_s = |miss_req;
        gnt_s     = ptr_r;
        cand_s    = ptr_r;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_s = CH_W'((int'(ptr_r) + k) % NUM_CH);
            gnt_s  = miss_req[cand_s] ? cand_s : gnt_s;
        end
    end

    assign sel_addr_s         = miss_addr[int'(gnt_s) * ADDR_W +: ADDR_W];
    assign unused_addr_bits_s = ^sel_addr_s[IDX_W:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_s = sel_addr_s[IDX_W:1];
`else
    assign start_s = {IDX_W{1'b0}};
`endif

    // Word order wraps naturally in IDX_W bits, giving modulo-block rotation from the start word.
    assign issue_word_s = start_r + issue_cnt_r[IDX_W-1:0];
    assign ret_word_s   = start_r + ret_cnt_r;
    assign grant_oh_s   = NUM_CH'(1'b1) << gnt_ch_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and output decode; returned words pass straight through to the granted cache.
    always_comb begin
        state_s         = state_r;
        mem_en          = 1'b0;
        mem_addr        = {ADDR_W{1'b0}};
        fill_we         = {NUM_CH{1'b0}};
        fill_word_idx   = {IDX_W{1'b0}};
        fill_data       = {DATA_W{1'b0}};
        tag_we          = {NUM_CH{1'b0}};
        fill_done       = {NUM_CH{1'b0}};
        busy            = 1'b0;
        crit_word_ready = {NUM_CH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                busy = 1'b1;
                if (!issue_cnt_r[IDX_W]) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_hi_r, issue_word_s, 1'b0};
                end else begin
                    mem_en   = 1'b0;
                end
                if (mem_data_valid) begin
                    fill_we       = grant_oh_s;
                    fill_word_idx = ret_word_s;
                    fill_data     = mem_data;
`ifdef CRITICAL_WORD_FIRST_EN
                    crit_word_ready = (ret_cnt_r == {IDX_W{1'b0}}) ? grant_oh_s : {NUM_CH{1'b0}};
`endif
                    if (ret_cnt_r == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        tag_we  = grant_oh_s;
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                fill_done = grant_oh_s;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Grant latch, round-robin pointer and the issue/return counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= {CH_W{1'b0}};
            gnt_ch_r    <= {CH_W{1'b0}};
            base_hi_r   <= {(ADDR_W-IDX_W-1){1'b0}};
            start_r     <= {IDX_W{1'b0}};
            issue_cnt_r <= {(IDX_W+1){1'b0}};
            ret_cnt_r   <= {IDX_W{1'b0}};
        end else if (state_r == ST_IDLE && req_any_s) begin
            gnt_ch_r    <= gnt_s;
            ptr_r       <= CH_W'((int'(gnt_s) + 1) % NUM_CH);
            base_hi_r   <= sel_addr_s[ADDR_W-1:IDX_W+1];
            start_r     <= start_s;
            issue_cnt_r <= {(IDX_W+1){1'b0}};
            ret_cnt_r   <= {IDX_W{1'b0}};
        end else if (state_r == ST_FILL) begin
            if (mem_en) begin
                issue_cnt_r <= issue_cnt_r + (IDX_W+1)'(1'b1);
            end
            if (mem_data_valid) begin
                ret_cnt_r <= ret_cnt_r + IDX_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: directed scenarios plus a randomized phase,
// each cycle compared against a timeline model of the fill protocol and a latency-queue memory.
module tb_cache_fill_arbiter;
    localparam int NUM_CH = 2;
    localparam int W      = 8;
    localparam int L      = 4;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  miss_req;
    logic [31:0] miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic [1:0]  fill_we;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic [1:0]  tag_we;
    logic [1:0]  fill_done;
    logic        busy;
    logic [1:0]  crit_word_ready;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
        .mem_data(mem_data), .fill_we(fill_we), .fill_word_idx(fill_word_idx),
        .fill_data(fill_data), .tag_we(tag_we), .fill_done(fill_done), .busy(busy),
        .crit_word_ready(crit_word_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          g_cyc = -1;
    int          g_ch = 0;
    int          g_s = 0;
    int          ptr = 0;
    int          drop_ch = -1;
    int          spur_pct = 0;
    bit          rand_mode = 1'b0;
    bit          seq_mode = 1'b0;
    logic [15:0] g_base = 16'h0000;
    logic [15:0] key = 16'h0000;
    logic [15:0] ch_addr [NUM_CH];
    int          pend_due [$];
    logic [15:0] pend_dat [$];

    // Memory contents as a pure function of the word address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (seq_mode) return 16'hA000 + {13'd0, a[3:1]};
        return (a * 16'd40503) ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_fill_we"}, 32'(fill_we), 32'd0);
        chk({tag, "_idx"}, 32'(fill_word_idx), 32'd0);
        chk({tag, "_fill_data"}, 32'(fill_data), 32'd0);
        chk({tag, "_tag_we"}, 32'(tag_we), 32'd0);
        chk({tag, "_fill_done"}, 32'(fill_done), 32'd0);
        chk({tag, "_crit"}, 32'(crit_word_ready), 32'd0);
    endtask

    // One clock cycle: apply stimulus, advance the model, drive memory, compare, record issues.
    task automatic step();
        int   t;
        int   wi;
        int   c;
        logic exp_en;
        logic exp_wr;
        if (drop_ch >= 0) begin
            miss_req[drop_ch] = 1'b0;
            drop_ch = -1;
        end
        if (rand_mode) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!miss_req[ch] && $urandom_range(7) == 0) begin
                    ch_addr[ch]  = 16'($urandom);
                    miss_req[ch] = 1'b1;
                end
            end
        end
        miss_addr = {ch_addr[1], ch_addr[0]};
        if ((g_cyc < 0 || cyc > g_cyc + W + L + 1) && miss_req != 2'b00) begin
            c = ptr;
            while (!miss_req[c]) c = (c + 1) % NUM_CH;
            g_cyc  = cyc;
            g_ch   = c;
            g_base = ch_addr[c] & 16'hFFF0;
            g_s    = CWF ? int'(ch_addr[c][3:1]) : 0;
            ptr    = (c + 1) % NUM_CH;
        end
        t = (g_cyc < 0) ? -1 : cyc - g_cyc;
        while (pend_due.size() > 0 && pend_due[0] < cyc) begin
            void'(pend_due.pop_front());
            void'(pend_dat.pop_front());
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = pend_dat.pop_front();
            void'(pend_due.pop_front());
        end else if ((t < 1 || t > W + L) && $urandom_range(99) < spur_pct) begin
            mem_data_valid = 1'b1;
            mem_data       = 16'hDEAD;
        end else begin
            mem_data_valid = 1'b0;
            mem_data       = 16'($urandom);
        end
        #1;
        exp_en = (t >= 1 && t <= W);
        exp_wr = (t >= L + 1 && t <= W + L);
        chk("busy", 32'(busy), 32'(t >= 1 && t <= W + L + 1));
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(g_base + 16'(2 * ((g_s + t - 1) % W))));
        chk("fill_we", 32'(fill_we), exp_wr ? (32'd1 << g_ch) : 32'd0);
        if (exp_wr) begin
            wi = (g_s + t - 1 - L) % W;
            chk("fill_idx", 32'(fill_word_idx), 32'(wi));
            chk("fill_data", 32'(fill_data), 32'(mem_word(g_base + 16'(2 * wi))));
        end
        chk("tag_we", 32'(tag_we), (t == W + L) ? (32'd1 << g_ch) : 32'd0);
        chk("fill_done", 32'(fill_done), (t == W + L + 1) ? (32'd1 << g_ch) : 32'd0);
        chk("crit", 32'(crit_word_ready), (CWF && t == L + 1) ? (32'd1 << g_ch) : 32'd0);
        if (mem_en === 1'b1) begin
            pend_due.push_back(cyc + L);
            pend_dat.push_back(mem_word(mem_addr));
        end
        if (t == W + L + 1) drop_ch = g_ch;
        if (rand_mode && t >= 1 && t <= W + L && $urandom_range(3) == 0) ch_addr[g_ch] = 16'($urandom);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        rst      = 1'b1;
        miss_req = 2'b00;
        #1;
        chk_all_zero("async_rst");
        g_cyc   = -1;
        ptr     = 0;
        drop_ch = -1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        miss_req       = 2'b00;
        miss_addr      = 32'h0000_0000;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;
        ch_addr[0]     = 16'h0000;
        ch_addr[1]     = 16'h0000;
        key            = 16'($urandom);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Basic fill of ch0 at 0x1236 with incrementing memory data.
        seq_mode   = 1'b1;
        ch_addr[0] = 16'h1236;
        miss_req   = 2'b01;
        repeat (15) step();
        seq_mode = 1'b0;

        // Spurious returns while idle.
        spur_pct = 100;
        repeat (4) step();
        spur_pct = 0;

        // ch1 drops its request at cycle 3 of its fill.
        ch_addr[1] = 16'($urandom);
        miss_req   = 2'b10;
        repeat (3) step();
        miss_req[1] = 1'b0;
        repeat (12) step();

        // Two simultaneous pairs, each served ch0 then ch1.
        repeat (2) begin
            ch_addr[0] = 16'($urandom);
            ch_addr[1] = 16'($urandom);
            miss_req   = 2'b11;
            repeat (30) step();
        end

        // Reset during cycle 7 of a fill, let late data drain, then a fresh miss.
        ch_addr[0] = 16'($urandom);
        miss_req   = 2'b01;
        repeat (7) step();
        async_reset();
        repeat (6) step();
        ch_addr[1] = 16'($urandom);
        miss_req   = 2'b10;
        repeat (15) step();

        // Randomized traffic with spurious returns and post-grant address changes.
        rand_mode = 1'b1;
        spur_pct  = 20;
        repeat (600) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shared miss-handling engine for the cached pipeline.
- Arbitrates block-fill requests from NUM_CH caches (default ch0 = I-cache, ch1 = D-cache) onto one pipelined multi-cycle memory port.
- Issues a burst of word reads per miss, steers returning words into the granted cache's data array, then writes that cache's tag.
- Sits between the cache arrays and main memory; the pipeline stall logic observes miss_req/fill_done.

Parameters:
NUM_CH, 2, number of requesting caches (1..4)
WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2, 2..16)
MEM_LATENCY, 4, cycles from mem_en/mem_addr issue to mem_data_valid (1..8)
ADDR_W, 16, byte-address width
DATA_W, 16, word width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
miss_req  in  NUM_CH  per-channel miss level; held until that channel's fill_done
miss_addr  in  NUM_CH*ADDR_W  per-channel missing byte address; ch k at [k*ADDR_W +: ADDR_W]
mem_en  out  1  read issue strobe to memory
mem_addr  out  ADDR_W  read byte address
mem_data_valid  in  1  returned word valid
mem_data  in  DATA_W  returned word
fill_we  out  NUM_CH  one-hot data-array write enable
fill_word_idx  out  log2(WORDS_PER_BLOCK)  word index within block for fill_we
fill_data  out  DATA_W  word to write (= mem_data)
tag_we  out  NUM_CH  one-hot tag/valid write, asserted with the last word
fill_done  out  NUM_CH  one-cycle completion pulse
busy  out  1  high when state != IDLE
crit_word_ready  out  NUM_CH  early-restart pulse (see Optional Feature)

Behaviour:
- Reset: async; state = IDLE, round-robin pointer = 0, all counters 0; every output 0.
- Block base = miss_addr with the low log2(WORDS_PER_BLOCK)+1 bits cleared. Words are 2 bytes.
- IDLE: if any miss_req, grant the first requester at or after the pointer (wrapping). Latch channel and base. Pointer <= granted+1 mod NUM_CH. Next state FILL. With no request, remain IDLE.
- FILL, issue side: issue counter i = 0..WORDS_PER_BLOCK-1. mem_en=1 and mem_addr=base+2*i on consecutive cycles with no gaps. mem_en=0 once all words are issued.
- FILL, return side: return counter r counts mem_data_valid.
  - Each valid: fill_we[granted]=1, fill_word_idx=word(r), fill_data=mem_data, same cycle (combinational pass-through).
  - When r = WORDS_PER_BLOCK-1 with valid: tag_we[granted]=1 in the same cycle, then next state DONE.
- DONE: fill_done[granted]=1 for one cycle, next state IDLE.
- Timing: request first seen in IDLE at cycle 0, FILL at cycle 1, last word at WORDS_PER_BLOCK+MEM_LATENCY, fill_done at WORDS_PER_BLOCK+MEM_LATENCY+1. With defaults this is 13.
- The next grant can occur in the IDLE cycle right after DONE; there is no back-to-back grant from DONE.
- mem_data_valid while IDLE or DONE is ignored, with no writes. This covers stale data after reset.
- miss_req dropped mid-fill: the fill completes normally (no abort). miss_addr changes after grant are ignored.
- A simultaneous request on all channels is served strictly round-robin. A channel cannot be starved for more than NUM_CH-1 fills.
- Reset mid-FILL: immediate IDLE with outputs 0. The partially filled block stays invalid because tag_we never fired.

Optional Feature:
CRITICAL_WORD_FIRST_EN:
- Defined: issue order starts at the word index of the latched miss_addr (bits [log2(WORDS_PER_BLOCK):1]) and wraps modulo WORDS_PER_BLOCK. fill_word_idx follows the same order. crit_word_ready[granted] pulses with the first returned word.
- Undefined: issue order starts at word 0 and crit_word_ready is tied to 0.
- Latency to fill_done is identical in both cases.

Test Plan:
- Reset, then ch0 miss_addr=0x1236, memory returns 0xA000+i: mem_addr 0x1230..0x123E on cycles 1..8; fill_we[0] idx 0..7 on cycles 5..12; tag_we[0] on cycle 12; fill_done[0] on cycle 13.
- ch0 and ch1 raise miss_req together: ch0 is filled first, then ch1 is granted in the IDLE cycle after fill_done[0]. The next simultaneous pair grants ch0 again (pointer=0).
- Spurious mem_data_valid with data 0xDEAD while IDLE: no fill_we or tag_we; busy=0.
- Assert rst at cycle 7 of a fill: all outputs 0 asynchronously. Late returned data produces no writes. A new miss after reset completes in 13 cycles.
- ch1 drops miss_req at cycle 3: the fill still completes, with fill_done[1] at cycle 13.
- With CRITICAL_WORD_FIRST_EN, miss_addr=0x123A: mem_addr order is 0x123A, 0x123C, 0x123E, 0x1230..0x1238. crit_word_ready[0] fires at cycle 5 with idx=5.
